mem_wait_ctrl: RTL and testbench
================================

# mem_wait_ctrl

Memory-stage wait-state controller for the pipelined core. Turns a load or store in the Memory stage into a req/ack transaction on a variable-latency data memory. While the transaction is outstanding it drives the stage enables, freezing the pipeline and bubbling Writeback. It is the counterpart to the decode-side load-use stall unit: that unit stalls on operand hazards, this one stalls on memory latency.

## Interface

- DATA_WIDTH, 32, data and address width
- TIMEOUT, 255, maximum cycles in BUSY without ack before abort (1..255)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- MemReadM  in  1  Memory-stage instruction is a load
- MemWriteM  in  1  Memory-stage instruction is a store; never high together with MemReadM
- ALUResultM  in  DATA_WIDTH  access address
- WriteDataM  in  DATA_WIDTH  store data
- ReadDataM  out  DATA_WIDTH  captured load data, valid in DONE
- mem_req  out  1  request to data memory
- mem_we  out  1  write strobe, qualified by mem_req
- mem_addr  out  DATA_WIDTH  request address
- mem_wdata  out  DATA_WIDTH  request write data
- mem_ack  in  1  single-cycle completion pulse from memory
- mem_rdata  in  DATA_WIDTH  read data, valid with mem_ack
- PCen, Fen, Den, Een  out  1 each  enables for PC, F/D, D/E and E/M registers
- Wrst  out  1  clears the M/W register (bubble)
- mem_err  out  1  one-cycle timeout indication

## Operation

- FSM states are IDLE, BUSY and DONE; reset state is IDLE.
- access = MemReadM | MemWriteM.
- IDLE
  - access=0: no stall.
  - access=1: freeze is asserted combinationally in the same cycle; next state is BUSY; the timer clears.
- BUSY
  - mem_req=1; mem_we=MemWriteM; mem_addr=ALUResultM; mem_wdata=WriteDataM. Inputs are stable because the pipeline is frozen.
  - Freeze is held. The timer increments every cycle.
  - mem_ack=1: capture mem_rdata into ReadDataM (stores capture 0); next state is DONE.
  - mem_ack=0 and timer==TIMEOUT-1: ReadDataM<=0; mem_err pulses in the following DONE cycle; next state is DONE.
- DONE
  - No freeze; mem_req=0. The Memory-stage instruction advances with ReadDataM.
  - Next state is always IDLE.
  - The next access is detected in the following IDLE cycle, because MemReadM/MemWriteM in DONE still belong to the completed instruction.
- Freeze means PCen=Fen=Den=Een=0 and Wrst=1. No freeze means enables=1 and Wrst=0.
- At top level the enables are ANDed and the flushes ORed with the load-use unit's outputs. While freeze is asserted, the top level gates the load-use unit's Drst to 0, so the frozen Decode instruction is not lost.
- mem_ack outside BUSY is ignored; it does not change state or ReadDataM.

## Timing

- Reset values: state IDLE, ReadDataM 0, timer 0, mem_err 0.
- With rst low and no access after the reset edge: mem_req 0, enables 1, Wrst 0.
- Memory latency is measured from the first mem_req cycle. Ack in the k-th BUSY cycle (k≥1) gives a freeze of k+1 cycles: the IDLE detect cycle plus k BUSY cycles. DONE follows, with no freeze.
- Minimum cost of an access is 2 stall cycles (ack in first BUSY cycle); back-to-back accesses are separated by DONE and IDLE.
- Timeout gives exactly TIMEOUT BUSY cycles, then DONE with mem_err=1 for one cycle.
- Reset mid-transaction: at the rst edge state becomes IDLE and the timer and ReadDataM become 0. mem_req is 0 from the next cycle. A late mem_ack is ignored.
- mem_ack and timeout in the same cycle: ack wins, mem_err stays 0, and data is captured.

## Structure

- Shared package pipe_pkg: enum mem_state_t {IDLE, BUSY, DONE}; localparam for default TIMEOUT.
- One sub-module, wait_timer: an 8-bit counter with clear/enable and an expired flag (count==TIMEOUT-1).
- Everything else lives in mem_wait_ctrl: FSM register, ReadDataM/mem_err registers, and combinational enable/request decode.

## Test plan

- Load to 0x100, ack in 3rd BUSY cycle, rdata 0xDEADBEEF → 4 freeze cycles (PCen=0, Wrst=1), then DONE with ReadDataM=0xDEADBEEF and enables=1; mem_req high exactly 3 cycles.
- Store to 0x200, data 0x12345678, ack in 1st BUSY cycle → mem_we=1, mem_addr=0x200, mem_wdata=0x12345678 for 1 cycle; 2 freeze cycles; ReadDataM=0.
- Two consecutive loads, each acked in cycle 1 → sequence IDLE(freeze), BUSY, DONE, IDLE(freeze), BUSY, DONE; second data captured correctly.
- Load, no ack, TIMEOUT=4 → 4 BUSY cycles, then DONE with mem_err=1 and ReadDataM=0; a stray ack one cycle later is ignored.
- rst asserted in 2nd BUSY cycle → next cycle state IDLE, mem_req=0, enables=1; a late ack leaves ReadDataM=0.
- Ack on the timeout cycle → mem_err=0 and rdata captured.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline types: memory wait-state FSM encoding and default abort limit.
package pipe_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  localparam int TIMEOUT_DEFAULT = 255;
  localparam int TIMER_W         = 8;

endpackage

// File: rtl/mem_wait_ctrl_if.sv
// Data-memory req/ack bus; the wait controller is master, the memory is slave.
interface mem_wait_ctrl_if #(
  parameter int DATA_WIDTH = 32
);

  logic                  mem_req;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/wait_timer.sv
// Cycle counter for an outstanding memory access; expired_o flags the last
// permitted wait cycle (count == TIMEOUT-1). Clear has priority over enable.
module wait_timer
  import pipe_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [TIMER_W-1:0] LAST = TIMER_W'(TIMEOUT - 1);

  logic [TIMER_W-1:0] count_q;
  logic [TIMER_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + TIMER_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == LAST);

endmodule

// File: rtl/mem_wait_ctrl.sv
// Memory-stage wait-state controller: issues one req/ack transaction per load/store
// and freezes the pipeline (enables low, Writeback bubbled) until it completes or times out.
module mem_wait_ctrl
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = TIMEOUT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MemReadM,
  input  logic                  MemWriteM,
  input  logic [DATA_WIDTH-1:0] ALUResultM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  output logic [DATA_WIDTH-1:0] ReadDataM,
  mem_wait_ctrl_if.master       mem,
  output logic                  PCen,
  output logic                  Fen,
  output logic                  Den,
  output logic                  Een,
  output logic                  Wrst,
  output logic                  mem_err
);

  mem_state_t            state_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;

  logic access;
  logic freeze;
  logic busy;
  logic timer_exp;

  assign access = MemReadM | MemWriteM;
  assign busy   = (state_q == BUSY);

  wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (!busy),
    .en_i      (busy),
    .expired_o (timer_exp)
  );

  // In DONE the M-stage controls still describe the finished access, so only IDLE detects.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (access) state_q <= BUSY;
        end
        BUSY: begin
          if (mem.mem_ack) begin
            state_q <= DONE;
            rdata_q <= MemReadM ? mem.mem_rdata : '0;
          end else if (timer_exp) begin
            state_q <= DONE;
            rdata_q <= '0;
            err_q   <= 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign freeze = busy | ((state_q == IDLE) & access);

  assign PCen = !freeze;
  assign Fen  = !freeze;
  assign Den  = !freeze;
  assign Een  = !freeze;
  assign Wrst = freeze;

  assign mem.mem_req   = busy;
  assign mem.mem_we    = busy & MemWriteM;
  assign mem.mem_addr  = ALUResultM;
  assign mem.mem_wdata = WriteDataM;

  assign ReadDataM = rdata_q;
  assign mem_err   = err_q;

endmodule

// File: tb/tb_mem_wait_ctrl.sv
// Directed bench for mem_wait_ctrl with TIMEOUT=4; inputs change 1 ns after the
// rising edge and outputs are checked 1 ns after that.
module tb_mem_wait_ctrl;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          MemReadM;
  logic          MemWriteM;
  logic [DW-1:0] ALUResultM;
  logic [DW-1:0] WriteDataM;
  logic [DW-1:0] ReadDataM;
  logic          PCen, Fen, Den, Een, Wrst, mem_err;

  int total = 0;
  int bad   = 0;

  mem_wait_ctrl_if #(.DATA_WIDTH(DW)) mif ();

  mem_wait_ctrl #(
    .DATA_WIDTH (DW),
    .TIMEOUT    (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .mem        (mif),
    .PCen       (PCen),
    .Fen        (Fen),
    .Den        (Den),
    .Een        (Een),
    .Wrst       (Wrst),
    .mem_err    (mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] en_vec();
    return 32'({PCen, Fen, Den, Een, Wrst});
  endfunction

  // One access from its IDLE detect cycle through DONE; ack_k=0 means never ack.
  task automatic xact(input string tag, input logic rd, input logic wr,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input int ack_k, input logic [31:0] rdata,
                      input int exp_busy, input logic [31:0] exp_rd, input logic exp_err);
    int frz;
    int req;
    bit done;
    frz  = 0;
    req  = 0;
    done = 1'b0;
    cyc();
    MemReadM    = rd;
    MemWriteM   = wr;
    ALUResultM  = addr;
    WriteDataM  = wdata;
    mif.mem_ack = 1'b0;
    #1;
    chk({tag, ".idle_req"}, 32'(mif.mem_req), 32'(0));
    if (en_vec() == 32'(5'b00001)) frz++;
    for (int k = 1; k <= 300 && !done; k++) begin
      cyc();
      mif.mem_ack = 1'b0;
      #1;
      if (!mif.mem_req) begin
        done = 1'b1;
      end else begin
        req++;
        if (en_vec() == 32'(5'b00001)) frz++;
        chk({tag, ".we"},    32'(mif.mem_we), 32'(wr));
        chk({tag, ".addr"},  mif.mem_addr, addr);
        chk({tag, ".wdata"}, mif.mem_wdata, wdata);
        if (k == ack_k) begin
          mif.mem_ack   = 1'b1;
          mif.mem_rdata = rdata;
        end
      end
    end
    chk({tag, ".done_seen"},     32'(done), 32'(1));
    chk({tag, ".busy_cycles"},   32'(req), 32'(exp_busy));
    chk({tag, ".freeze_cycles"}, 32'(frz), 32'(exp_busy + 1));
    chk({tag, ".rdata"},         ReadDataM, exp_rd);
    chk({tag, ".err"},           32'(mem_err), 32'(exp_err));
    chk({tag, ".done_en"},       en_vec(), 32'(5'b11110));
  endtask

  task automatic idle_cycle(input string tag, input logic ack);
    cyc();
    MemReadM      = 1'b0;
    MemWriteM     = 1'b0;
    mif.mem_ack   = ack;
    mif.mem_rdata = 32'hBAD0BAD0;
    #1;
    chk({tag, ".req"}, 32'(mif.mem_req), 32'(0));
    chk({tag, ".en"},  en_vec(), 32'(5'b11110));
    chk({tag, ".err"}, 32'(mem_err), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst           = 1'b1;
    MemReadM      = 1'b0;
    MemWriteM     = 1'b0;
    ALUResultM    = '0;
    WriteDataM    = '0;
    mif.mem_ack   = 1'b0;
    mif.mem_rdata = '0;

    cyc();
    cyc();
    chk("rst.rdata", ReadDataM, 32'h0);
    chk("rst.err",   32'(mem_err), 32'(0));
    chk("rst.req",   32'(mif.mem_req), 32'(0));
    rst = 1'b0;
    cyc();
    chk("post_rst.en",  en_vec(), 32'(5'b11110));
    chk("post_rst.req", 32'(mif.mem_req), 32'(0));

    xact("ld1", 1'b1, 1'b0, 32'h100, 32'h0, 3, 32'hDEADBEEF, 3, 32'hDEADBEEF, 1'b0);
    xact("st1", 1'b0, 1'b1, 32'h200, 32'h12345678, 1, 32'hFFFF0000, 1, 32'h0, 1'b0);
    xact("b2bA", 1'b1, 1'b0, 32'h300, 32'h0, 1, 32'h11111111, 1, 32'h11111111, 1'b0);
    xact("b2bB", 1'b1, 1'b0, 32'h304, 32'h0, 1, 32'h22222222, 1, 32'h22222222, 1'b0);
    xact("tmo", 1'b1, 1'b0, 32'h500, 32'h0, 0, 32'h0, 4, 32'h0, 1'b1);

    idle_cycle("stray_ack", 1'b1);
    idle_cycle("after_stray", 1'b0);
    chk("after_stray.rdata", ReadDataM, 32'h0);

    xact("ack_on_tmo", 1'b1, 1'b0, 32'h600, 32'h0, 4, 32'hCAFEF00D, 4, 32'hCAFEF00D, 1'b0);

    // Reset lands in the second BUSY cycle, then a late ack arrives.
    cyc();
    MemReadM   = 1'b1;
    ALUResultM = 32'h400;
    #1;
    chk("mrst.idle_en", en_vec(), 32'(5'b00001));
    cyc();
    chk("mrst.busy1_req", 32'(mif.mem_req), 32'(1));
    cyc();
    rst = 1'b1;
    #1;
    chk("mrst.busy2_req", 32'(mif.mem_req), 32'(1));
    cyc();
    rst           = 1'b0;
    MemReadM      = 1'b0;
    mif.mem_ack   = 1'b1;
    mif.mem_rdata = 32'h77777777;
    #1;
    chk("mrst.req",   32'(mif.mem_req), 32'(0));
    chk("mrst.en",    en_vec(), 32'(5'b11110));
    chk("mrst.rdata", ReadDataM, 32'h0);
    cyc();
    mif.mem_ack = 1'b0;
    #1;
    chk("mrst.late_ack_rdata", ReadDataM, 32'h0);
    chk("mrst.late_ack_req",   32'(mif.mem_req), 32'(0));

    xact("ld_final", 1'b1, 1'b0, 32'h700, 32'h0, 2, 32'h0BADCAFE, 2, 32'h0BADCAFE, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
